// File: rtl/serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// serial_adder_ctrl
//
// Purpose:
//   Adds two WIDTH-bit operands by time-sharing a single 1-bit full-adder
//   cell. One bit slice is processed per clock, LSB first, with a carry
//   flip-flop carrying between slices. A host starts an add with `start`
//   and sees the result on the one-cycle `done` pulse. The cost is WIDTH
//   cycles of latency; an add completes every WIDTH+2 cycles.
//
// Ports:
//   clk        in   1      single clock, rising-edge active
//   rst        in   1      synchronous reset, active-high
//   start      in   1      add request, sampled only while idle
//   a, b       in   WIDTH  operands, captured on the accepted start
//   carry_in   in   1      initial carry, captured on the accepted start
//   busy       out  1      high while bit slices are being processed
//   done       out  1      one-cycle pulse; sum/carry_out valid here
//   sum        out  WIDTH  result, held until the next accepted start
//   carry_out  out  1      final carry, held like sum
//   ovf        out  1      signed overflow (only with SERIAL_ADD_OVF_EN)
//
// Configuration:
//   `define SERIAL_ADD_OVF_EN adds the ovf port and its overflow logic.
// ---------------------------------------------------------------------------
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;

  logic [WIDTH-1:0] r_ra;
  logic [WIDTH-1:0] r_rb;
  logic             r_cff;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry_out;
  logic             r_busy;
  logic             r_done;
  logic             w_busy_nxt;
  logic             w_done_nxt;

  logic             w_s;
  logic             w_co;
  logic             w_last;

  // 1-bit full-adder cell working on the current LSB slice.
  assign w_s    = r_ra[0] ^ r_rb[0] ^ r_cff;
  assign w_co   = (r_ra[0] & r_rb[0]) | (r_cff & (r_ra[0] ^ r_rb[0]));
  assign w_last = (r_cnt == CW'(WIDTH - 1));

  // State register.
  // NOTE: clocked state uses non-blocking (<=) so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state logic.
  // NOTE: the default assignment at the top keeps this purely
  // combinational; a path that left w_next_state unassigned would infer a latch.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (start)  w_next_state = ST_SHIFT;
      ST_SHIFT: if (w_last) w_next_state = ST_DONE;
      ST_DONE:              w_next_state = ST_IDLE;
      default:              w_next_state = ST_IDLE;
    endcase
  end

  // Output decode from the next state, registered below so busy/done come
  // straight off flops and line up with the state they describe.
  always_comb begin
    w_busy_nxt = 1'b0;
    w_done_nxt = 1'b0;
    case (w_next_state)
      ST_SHIFT: w_busy_nxt = 1'b1;
      ST_DONE:  w_done_nxt = 1'b1;
      default:  ;
    endcase
  end

  // Datapath: operand shift registers, carry FF, bit counter, result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ra        <= '0;
      r_rb        <= '0;
      r_cff       <= 1'b0;
      r_cnt       <= '0;
      r_sum       <= '0;
      r_carry_out <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_ra  <= a;
            r_rb  <= b;
            r_cff <= carry_in;
            r_cnt <= '0;
            r_sum <= '0;
          end
        end
        ST_SHIFT: begin
          r_ra  <= r_ra >> 1;
          r_rb  <= r_rb >> 1;
          // Result bits enter at the MSB; after WIDTH shifts bit 0 is in place.
          r_sum <= {w_s, r_sum[WIDTH-1:1]};
          r_cff <= w_co;
          if (w_last) begin
            r_cnt       <= '0;
            r_carry_out <= w_co;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SERIAL_ADD_OVF_EN
  logic r_ovf;

  // On the MSB slice r_cff is the carry into the MSB; overflow is that
  // carry disagreeing with the carry out of the MSB.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (r_state == ST_IDLE && start) begin
      r_ovf <= 1'b0;
    end else if (r_state == ST_SHIFT && w_last) begin
      r_ovf <= r_cff ^ w_co;
    end
  end

  assign ovf = r_ovf;
`endif

  assign busy      = r_busy;
  assign done      = r_done;
  assign sum       = r_sum;
  assign carry_out = r_carry_out;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serial_adder_ctrl
//
// Directed bench for serial_adder_ctrl at WIDTH=8. Inputs change and
// outputs are sampled on the falling edge, away from the active edge.
// ovf checks are compiled in only when SERIAL_ADD_OVF_EN is defined.
// ---------------------------------------------------------------------------
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         carry_in;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         carry_out;
`ifdef SERIAL_ADD_OVF_EN
  logic         ovf;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .b         (b),
    .carry_in  (carry_in),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .carry_out (carry_out)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One complete add starting from a falling edge in IDLE. If glitch is
  // non-zero, start is pulsed (with a different operand A) during that
  // busy cycle and must be ignored. Ends on a falling edge back in IDLE.
  task automatic do_add(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic tcin, input logic [W-1:0] es, input logic ec,
                        input logic eo, input int glitch);
    int busy_cnt;
    int done_early;
    $display("add %s: %h + %h + %b -> expect sum %h cout %b ovf %b", tag, ta, tb_v, tcin, es, ec, eo);
    a = ta; b = tb_v; carry_in = tcin; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = ~ta; b = ~tb_v; carry_in = ~tcin;
    check({tag, " sum_cleared"}, sum, 0);
`ifdef SERIAL_ADD_OVF_EN
    check({tag, " ovf_cleared"}, ovf, 0);
`endif
    busy_cnt = 0;
    done_early = 0;
    for (int k = 1; k <= W; k++) begin
      if (k != 1) @(negedge clk);
      busy_cnt += int'(busy);
      done_early += int'(done);
      start = (glitch != 0 && k == glitch);
      if (start) a = 8'hAA;
    end
    check({tag, " busy_cycles"}, busy_cnt, W);
    check({tag, " no_early_done"}, done_early, 0);
    @(negedge clk);
    check({tag, " done"}, done, 1);
    check({tag, " busy_in_done"}, busy, 0);
    check({tag, " sum"}, sum, es);
    check({tag, " carry_out"}, carry_out, ec);
`ifdef SERIAL_ADD_OVF_EN
    check({tag, " ovf"}, ovf, eo);
`endif
    @(negedge clk);
    check({tag, " done_pulse_end"}, done, 0);
    check({tag, " idle_busy"}, busy, 0);
    check({tag, " sum_held"}, sum, es);
  endtask

  initial begin
    int done_q[$];
    int done_cnt;

    rst = 1'b1; start = 1'b0; a = '0; b = '0; carry_in = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst sum", sum, 0);
    check("rst carry_out", carry_out, 0);
`ifdef SERIAL_ADD_OVF_EN
    check("rst ovf", ovf, 0);
`endif

    // Basic add (signed view overflows: 90 + 51 > 127).
    do_add("5A+33", 8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 1'b1, 0);

    // Reset for two edges while idle clears the held result.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("idle_rst busy", busy, 0);
    check("idle_rst done", done, 0);
    check("idle_rst sum", sum, 0);
    check("idle_rst carry_out", carry_out, 0);
`ifdef SERIAL_ADD_OVF_EN
    check("idle_rst ovf", ovf, 0);
`endif

    // Carry and wrap-around corners.
    do_add("FF+01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 0);
    do_add("FF+FF+1", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 0);
    do_add("00+00+1", 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0, 0);
    do_add("FF+00+1", 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 0);

    // start pulsed during the 3rd busy cycle is ignored.
    do_add("10+20 glitch", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 3);

    // start held high: back-to-back adds, done every W+2 cycles.
    a = 8'h03; b = 8'h04; carry_in = 1'b0; start = 1'b1;
    done_cnt = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (done) begin
        done_q.push_back(n);
        check("b2b sum", sum, 8'h07);
      end
    end
    start = 1'b0;
    done_cnt = done_q.size();
    check("b2b done_count", done_cnt, 4);
    if (done_cnt > 0) check("b2b first_done", done_q[0], W + 1);
    for (int i = 1; i < done_cnt; i++) check("b2b done_gap", done_q[i] - done_q[i-1], W + 2);
    repeat (2) @(negedge clk);
    check("b2b stopped", busy, 0);

    // Reset on the 4th SHIFT cycle aborts the add.
    a = 8'h55; b = 8'h11; carry_in = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("abort busy_before", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort sum", sum, 0);
    check("abort carry_out", carry_out, 0);
    done_cnt = 0;
    for (int n = 0; n < W + 2; n++) begin
      @(negedge clk);
      done_cnt += int'(done) + int'(busy);
    end
    check("abort stays_idle", done_cnt, 0);
    do_add("0F+01", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, 0);

    // Signed-overflow vectors (sum/carry checked in every build).
    do_add("7F+01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 0);
    do_add("80+80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 0);
    do_add("FF+01 ovf", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
